peribus_ctrl: RTL and testbench

PERIBUS_CTRL -- requirements
Module: peribus_ctrl

---
 rtl/peribus_ctrl.sv | 126 ++++++++++++
 tb/tb_peribus_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/peribus_ctrl.sv
// Data-side bus splitter: plain memory accesses go straight to data memory, accesses
// to the PERI_BASE region stall the CPU for a req/ack handshake. Optional timeout: PERI_TIMEOUT_EN.
module peribus_ctrl #(
  parameter logic [3:0] PERI_BASE = 4'hF,
  parameter logic [7:0] TIMEOUT   = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        stall,
  output logic        memdatamuxcontrol,
  output logic [31:0] periread,
  output logic        peri_req,
  output logic        peri_we,
  output logic [31:0] peri_addr,
  output logic [31:0] peri_wdata,
  input  logic        peri_ack,
  input  logic [31:0] peri_rdata,
  output logic        peri_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state_reg, state_next;
  logic        is_peri;
  logic        timeout;
  logic        peri_req_reg;
  logic        peri_we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] periread_reg;

  assign is_peri = (addr[31:28] == PERI_BASE);
  assign dmem_re = memread & ~is_peri;
  assign dmem_we = memwrite & ~is_peri;

  assign peri_req   = peri_req_reg;
  assign peri_we    = peri_we_reg;
  assign peri_addr  = addr_reg;
  assign peri_wdata = wdata_reg;
  assign periread   = periread_reg;

`ifdef PERI_TIMEOUT_EN
  logic [7:0] cnt_reg;
  logic       err_reg;

  // Fires on the TIMEOUT-th REQ cycle without ack; a same-cycle ack takes precedence.
  assign timeout  = (state_reg == REQ) && !peri_ack && (cnt_reg == TIMEOUT - 8'd1);
  assign peri_err = err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= 8'd0;
      err_reg <= 1'b0;
    end else begin
      err_reg <= timeout;
      if (state_reg != REQ) begin
        cnt_reg <= 8'd0;
      end else if (!peri_ack) begin
        cnt_reg <= cnt_reg + 8'd1;
      end
    end
  end
`else
  assign timeout  = 1'b0;
  assign peri_err = 1'b0;
`endif

  always_comb begin
    state_next        = state_reg;
    stall             = 1'b0;
    memdatamuxcontrol = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((memread || memwrite) && is_peri) begin
          state_next = REQ;
          stall      = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (peri_ack || timeout) begin
          state_next = DONE;
        end
      end
      DONE: begin
        memdatamuxcontrol = ~peri_we_reg;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      peri_req_reg <= 1'b0;
      peri_we_reg  <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
      periread_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      peri_req_reg <= (state_next == REQ);
      // Write wins when both strobes are set, so peri_we simply follows memwrite.
      if (state_reg == IDLE && state_next == REQ) begin
        addr_reg    <= addr;
        wdata_reg   <= wdata;
        peri_we_reg <= memwrite;
      end
      if (state_reg == REQ && !peri_we_reg) begin
        if (peri_ack) begin
          periread_reg <= peri_rdata;
        end else if (timeout) begin
          periread_reg <= 32'hDEADBEEF;
        end
      end
    end
  end

endmodule

// File: tb/tb_peribus_ctrl.sv
// Directed bench for peribus_ctrl: dmem pass-through, peripheral load/store handshakes,
// dual strobes, stray acks, mid-access reset and (with PERI_TIMEOUT_EN) the timeout path.
module tb_peribus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread, memwrite;
  logic [31:0] addr, wdata;
  logic        dmem_re, dmem_we, stall, memdatamuxcontrol;
  logic [31:0] periread;
  logic        peri_req, peri_we;
  logic [31:0] peri_addr, peri_wdata;
  logic        peri_ack;
  logic [31:0] peri_rdata;
  logic        peri_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Values recorded by run_access for the scenario tasks to compare.
  int          stall_cycles, req_cycles;
  logic        hung, mux_done, err_done, req_done, we_seen;
  logic [31:0] addr_seen, wdata_seen;

  always #5 clk = ~clk;

  peribus_ctrl #(.PERI_BASE(4'hF), .TIMEOUT(8'd4)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .dmem_re(dmem_re), .dmem_we(dmem_we),
    .stall(stall), .memdatamuxcontrol(memdatamuxcontrol), .periread(periread),
    .peri_req(peri_req), .peri_we(peri_we), .peri_addr(peri_addr),
    .peri_wdata(peri_wdata), .peri_ack(peri_ack), .peri_rdata(peri_rdata),
    .peri_err(peri_err)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one CPU access, holding the strobes while stalled; acks on REQ cycle ack_at
  // (0 = never). Leaves the bench one cycle after DONE with strobes low.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at, input logic [31:0] rdat);
    int k = 0;
    memread = rd; memwrite = wr; addr = a; wdata = d; peri_ack = 1'b0;
    stall_cycles = 0; req_cycles = 0; we_seen = 1'b0; addr_seen = 32'h0; wdata_seen = 32'h0;
    #1;
    while (stall === 1'b1 && k < 50) begin
      stall_cycles++;
      if (peri_req === 1'b1) begin
        req_cycles++;
        we_seen = peri_we; addr_seen = peri_addr; wdata_seen = peri_wdata;
        if (req_cycles == ack_at) begin
          peri_ack = 1'b1; peri_rdata = rdat;
        end
      end
      @(posedge clk);
      #1;
      peri_ack = 1'b0; peri_rdata = 32'h0;
      #1;
      k++;
    end
    hung     = (k >= 50);
    mux_done = memdatamuxcontrol;
    err_done = peri_err;
    req_done = peri_req;
    memread = 1'b0; memwrite = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = 32'h0; wdata = 32'h0;
    peri_ack = 1'b0; peri_rdata = 32'h0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if (peri_req !== 1'b0) begin n_fail++; $display("FAIL reset_peri_req got=%b exp=0", peri_req); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    n_checks++; if (periread !== 32'h0) begin n_fail++; $display("FAIL reset_periread got=%h exp=00000000", periread); end
    n_checks++; if ({peri_addr, peri_wdata} !== 64'h0) begin n_fail++; $display("FAIL reset_latches got=%h/%h exp=0/0", peri_addr, peri_wdata); end
    n_checks++; if ({peri_we, peri_err, memdatamuxcontrol} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {peri_we, peri_err, memdatamuxcontrol}); end
    $display("reset: periread=%h peri_req=%b stall=%b", periread, peri_req, stall);
    next_cycle();
  endtask

  task automatic test_dmem_store();
    memwrite = 1'b1; addr = 32'h0000_0010; wdata = 32'hA5A5_A5A5;
    #1;
    n_checks++; if ({dmem_we, dmem_re, stall} !== 3'b100) begin n_fail++; $display("FAIL dmem_store_strobes got=%b exp=100", {dmem_we, dmem_re, stall}); end
    next_cycle();
    n_checks++; if (peri_req !== 1'b0) begin n_fail++; $display("FAIL dmem_store_no_req got=%b exp=0", peri_req); end
    memwrite = 1'b0; memread = 1'b1;
    #1;
    n_checks++; if ({dmem_re, dmem_we, stall} !== 3'b100) begin n_fail++; $display("FAIL dmem_load_strobes got=%b exp=100", {dmem_re, dmem_we, stall}); end
    $display("dmem access: addr=%h dmem_re=%b stall=%b peri_req=%b", addr, dmem_re, stall, peri_req);
    memread = 1'b0;
    next_cycle();
  endtask

  task automatic test_peri_load();
    memread = 1'b1; addr = 32'hF000_0004;
    #1;
    n_checks++; if (dmem_re !== 1'b0) begin n_fail++; $display("FAIL load_dmem_re got=%b exp=0", dmem_re); end
    run_access(1'b1, 1'b0, 32'hF000_0004, 32'h0, 3, 32'h1234_5678);
    n_checks++; if (hung !== 1'b0) begin n_fail++; $display("FAIL load_hang got=%b exp=0", hung); end
    n_checks++; if (stall_cycles != 4) begin n_fail++; $display("FAIL load_stall_cycles got=%0d exp=4", stall_cycles); end
    n_checks++; if ({we_seen, addr_seen} !== {1'b0, 32'hF000_0004}) begin n_fail++; $display("FAIL load_req_fields got=%b/%h exp=0/f0000004", we_seen, addr_seen); end
    n_checks++; if ({mux_done, req_done, err_done} !== 3'b100) begin n_fail++; $display("FAIL load_done_flags got=%b exp=100", {mux_done, req_done, err_done}); end
    n_checks++; if (periread !== 32'h1234_5678) begin n_fail++; $display("FAIL load_periread got=%h exp=12345678", periread); end
    $display("peri load: addr=%h stall_cycles=%0d periread=%h", addr_seen, stall_cycles, periread);
  endtask

  task automatic test_peri_store();
    run_access(1'b0, 1'b1, 32'hF000_0008, 32'hCAFE_0001, 1, 32'h5555_5555);
    n_checks++; if (hung !== 1'b0) begin n_fail++; $display("FAIL store_hang got=%b exp=0", hung); end
    n_checks++; if (stall_cycles != 2) begin n_fail++; $display("FAIL store_stall_cycles got=%0d exp=2", stall_cycles); end
    n_checks++; if ({we_seen, wdata_seen} !== {1'b1, 32'hCAFE_0001}) begin n_fail++; $display("FAIL store_req_fields got=%b/%h exp=1/cafe0001", we_seen, wdata_seen); end
    n_checks++; if (addr_seen !== 32'hF000_0008) begin n_fail++; $display("FAIL store_addr got=%h exp=f0000008", addr_seen); end
    n_checks++; if (mux_done !== 1'b0) begin n_fail++; $display("FAIL store_mux got=%b exp=0", mux_done); end
    n_checks++; if (periread !== 32'h1234_5678) begin n_fail++; $display("FAIL store_periread_hold got=%h exp=12345678", periread); end
    $display("peri store: wdata=%h stall_cycles=%0d periread=%h", wdata_seen, stall_cycles, periread);
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b1, 32'hF000_0000, 32'h0BAD_F00D, 2, 32'h7777_7777);
    n_checks++; if ({hung, we_seen} !== 2'b01) begin n_fail++; $display("FAIL both_we got=%b exp=01", {hung, we_seen}); end
    n_checks++; if (mux_done !== 1'b0) begin n_fail++; $display("FAIL both_mux got=%b exp=0", mux_done); end
    n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL both_stall_cycles got=%0d exp=3", stall_cycles); end
    n_checks++; if (periread !== 32'h1234_5678) begin n_fail++; $display("FAIL both_periread got=%h exp=12345678", periread); end
    $display("dual strobe: peri_we=%b stall_cycles=%0d", we_seen, stall_cycles);
    // Immediate follow-up load to a second peripheral address.
    run_access(1'b1, 1'b0, 32'hF000_0020, 32'h0, 1, 32'h0F0F_1234);
    n_checks++; if (stall_cycles != 2) begin n_fail++; $display("FAIL b2b_stall_cycles got=%0d exp=2", stall_cycles); end
    n_checks++; if (periread !== 32'h0F0F_1234) begin n_fail++; $display("FAIL b2b_periread got=%h exp=0f0f1234", periread); end
    $display("back-to-back load: addr=%h periread=%h", addr_seen, periread);
  endtask

  task automatic test_stray_ack();
    peri_ack = 1'b1; peri_rdata = 32'hFFFF_0000;
    next_cycle();
    peri_ack = 1'b0; peri_rdata = 32'h0;
    #1;
    n_checks++; if ({peri_req, stall, memdatamuxcontrol} !== 3'b000) begin n_fail++; $display("FAIL stray_ack_flags got=%b exp=000", {peri_req, stall, memdatamuxcontrol}); end
    n_checks++; if (periread !== 32'h0F0F_1234) begin n_fail++; $display("FAIL stray_ack_periread got=%h exp=0f0f1234", periread); end
    $display("stray ack: periread=%h peri_req=%b", periread, peri_req);
    next_cycle();
  endtask

  task automatic test_reset_mid();
    memread = 1'b1; addr = 32'hF000_0004;
    next_cycle();
    n_checks++; if (peri_req !== 1'b1) begin n_fail++; $display("FAIL mid_req_entered got=%b exp=1", peri_req); end
    reset = 1'b1; memread = 1'b0;
    next_cycle();
    reset = 1'b0;
    #1;
    n_checks++; if ({peri_req, stall} !== 2'b00) begin n_fail++; $display("FAIL mid_reset_flags got=%b exp=00", {peri_req, stall}); end
    n_checks++; if (periread !== 32'h0) begin n_fail++; $display("FAIL mid_reset_periread got=%h exp=00000000", periread); end
    next_cycle();
    n_checks++; if ({peri_req, stall, memdatamuxcontrol} !== 3'b000) begin n_fail++; $display("FAIL mid_reset_idle got=%b exp=000", {peri_req, stall, memdatamuxcontrol}); end
    $display("reset mid-access: peri_req=%b stall=%b periread=%h", peri_req, stall, periread);
  endtask

`ifdef PERI_TIMEOUT_EN
  task automatic test_timeout();
    run_access(1'b1, 1'b0, 32'hF000_0030, 32'h0, 0, 32'h0);
    n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles got=%0d exp=4", req_cycles); end
    n_checks++; if (err_done !== 1'b1) begin n_fail++; $display("FAIL to_err got=%b exp=1", err_done); end
    n_checks++; if (periread !== 32'hDEADBEEF) begin n_fail++; $display("FAIL to_periread got=%h exp=deadbeef", periread); end
    n_checks++; if (peri_err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got=%b exp=0", peri_err); end
    $display("timeout load: req_cycles=%0d periread=%h", req_cycles, periread);
    run_access(1'b1, 1'b0, 32'hF000_0034, 32'h0, 4, 32'h4444_AAAA);
    n_checks++; if ({err_done, req_cycles == 4} !== 2'b01) begin n_fail++; $display("FAIL to_ack_wins got=%b exp=01", {err_done, req_cycles == 4}); end
    n_checks++; if (periread !== 32'h4444_AAAA) begin n_fail++; $display("FAIL to_ack_periread got=%h exp=4444aaaa", periread); end
    $display("ack at timeout: err=%b periread=%h", err_done, periread);
  endtask
`endif

  initial begin
    test_reset();
    test_dmem_store();
    test_peri_load();
    test_peri_store();
    test_back_to_back();
    test_stray_ack();
`ifdef PERI_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
